// File: rtl/ram_arb_pkg.sv
// ============================================================================
// Module      : ram_arb_pkg
// Description : Shared constants and state encoding for the RAM arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ram_arb_pkg;

    // Arbitration modes
    localparam logic PRIO_RR    = 1'b0;
    localparam logic PRIO_FIXED = 1'b1;

    // Arbiter FSM states
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

endpackage

`default_nettype wire

// File: rtl/ram_arb_pick.sv
// ============================================================================
// Module      : ram_arb_pick
// Description : Combinational winner selection. Round-robin rotates the
//               request vector by the pointer (double-width trick) and
//               priority-encodes; fixed mode picks the lowest index.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_arb_pick
    import ram_arb_pkg::*;
#(
    parameter int NUM_PORTS = 2,
    parameter int GW        = 1
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [GW-1:0]        ptr,
    input  logic                 mode,
    output logic [GW-1:0]        winner,
    output logic                 valid
);

    // Requests rotated so that the pointer position lands at bit 0
    logic [NUM_PORTS-1:0] rot;
    logic [GW:0]          sum;
    logic                 found;

    assign rot   = NUM_PORTS'({req, req} >> ptr);
    assign valid = |req;

    // Priority-encode either the raw or the rotated vector
    always_comb begin
        winner = '0;
        sum    = '0;
        found  = 1'b0;
        if (mode == PRIO_FIXED) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (!found && req[i]) begin
                    winner = GW'(i);
                    found  = 1'b1;
                end
            end
        end else begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (!found && rot[i]) begin
                    sum   = {1'b0, ptr} + (GW+1)'(i);
                    found = 1'b1;
                end
            end
            // Undo the rotation modulo NUM_PORTS
            if (sum >= (GW+1)'(NUM_PORTS)) begin
                sum = sum - (GW+1)'(NUM_PORTS);
            end
            winner = sum[GW-1:0];
        end
    end

endmodule

`default_nettype wire

// File: rtl/ram_arb.sv
// ============================================================================
// Module      : ram_arb
// Description : N-port req/ack arbiter in front of a single-port shared RAM.
//               Round-robin or fixed priority, combinational ack passthrough,
//               sticky per-port flag for requests withdrawn before ack.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_arb
    import ram_arb_pkg::*;
#(
    parameter  int NUM_PORTS = 2,
    parameter  int AW        = 17,
    parameter  int DW        = 32,
    parameter  int PRIO_MODE = 0,
    localparam int GW        = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                    hclk,
    input  logic                    hrstn,
    input  logic [NUM_PORTS-1:0]    up_wr_req,
    input  logic [NUM_PORTS-1:0]    up_rd_req,
    input  logic [NUM_PORTS*AW-1:0] up_addr,
    input  logic [NUM_PORTS*DW-1:0] up_wdata,
    output logic [NUM_PORTS-1:0]    up_wr_ack,
    output logic [NUM_PORTS-1:0]    up_rd_ack,
    output logic [DW-1:0]           up_rdata,
    output logic                    ram_wr_req,
    output logic                    ram_rd_req,
    output logic [AW-1:0]           ram_addr,
    output logic [DW-1:0]           ram_wdata,
    input  logic                    ram_wr_ack,
    input  logic                    ram_rd_ack,
    input  logic [DW-1:0]           ram_rdata,
    output logic                    busy,
    output logic [GW-1:0]           grant_id,
    output logic [NUM_PORTS-1:0]    err_drop
);

    localparam logic MODE = (PRIO_MODE == 1) ? PRIO_FIXED : PRIO_RR;

    state_t               state;
    logic [GW-1:0]        grant;
    logic                 op_wr;
    logic [GW-1:0]        rr_ptr;
    logic [NUM_PORTS-1:0] err_flags;

    logic [GW-1:0]        pick_winner;
    logic                 pick_valid;
    logic                 pick_wr;
    logic                 sel_wr;
    logic                 sel_rd;
    logic [AW-1:0]        sel_addr;
    logic [DW-1:0]        sel_wdata;
    logic [NUM_PORTS-1:0] grant_oh;
    logic                 in_busy;
    logic                 live;
    logic                 wr_done;
    logic                 rd_done;
    logic                 dropped;
    logic [GW-1:0]        next_ptr;

    ram_arb_pick #(
        .NUM_PORTS (NUM_PORTS),
        .GW        (GW)
    ) u_pick (
        .req    (up_wr_req | up_rd_req),
        .ptr    (rr_ptr),
        .mode   (MODE),
        .winner (pick_winner),
        .valid  (pick_valid)
    );

    // Mux the granted port's live inputs and decode the grant one-hot
    always_comb begin
        sel_wr    = 1'b0;
        sel_rd    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        pick_wr   = 1'b0;
        grant_oh  = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (grant == GW'(i)) begin
                sel_wr      = up_wr_req[i];
                sel_rd      = up_rd_req[i];
                sel_addr    = up_addr[i*AW +: AW];
                sel_wdata   = up_wdata[i*DW +: DW];
                grant_oh[i] = 1'b1;
            end
            if (pick_winner == GW'(i)) begin
                pick_wr = up_wr_req[i];
            end
        end
    end

    // Downstream request follows the latched op, gated by the winner's req
    assign in_busy    = (state == ST_BUSY);
    assign live       = op_wr ? sel_wr : sel_rd;
    assign ram_wr_req = in_busy & op_wr & live;
    assign ram_rd_req = in_busy & ~op_wr & live;
    assign ram_addr   = in_busy ? sel_addr  : '0;
    assign ram_wdata  = in_busy ? sel_wdata : '0;
    assign up_rdata   = ram_rdata;

    // Only an ack of the matching op type completes the grant
    assign wr_done    = ram_wr_req & ram_wr_ack;
    assign rd_done    = ram_rd_req & ram_rd_ack;
    assign dropped    = in_busy & ~live;
    assign up_wr_ack  = grant_oh & {NUM_PORTS{wr_done}};
    assign up_rd_ack  = grant_oh & {NUM_PORTS{rd_done}};

    assign next_ptr   = (grant == GW'(NUM_PORTS - 1)) ? '0 : grant + GW'(1);

    assign busy       = in_busy;
    assign grant_id   = grant;
    assign err_drop   = err_flags;

    // Arbiter FSM: grant in IDLE, wait for ack or withdrawal in BUSY
    always_ff @(posedge hclk or negedge hrstn) begin
        if (!hrstn) begin
            state     <= ST_IDLE;
            grant     <= '0;
            op_wr     <= 1'b0;
            rr_ptr    <= '0;
            err_flags <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_valid) begin
                        grant <= pick_winner;
                        op_wr <= pick_wr;
                        state <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (wr_done || rd_done || dropped) begin
                        state  <= ST_IDLE;
                        rr_ptr <= next_ptr;
                    end
                    if (dropped) begin
                        err_flags <= err_flags | grant_oh;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire
